mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 6 +
 rtl/mem_array.sv | 19 +
 rtl/mem_responder.sv | 87 ++++++++
 tb/tb_mem_responder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared size/state encodings and word geometry for the memory responder.
package mem_pkg;
    localparam int WORD_BYTES = 4;
    typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10} size_e;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
endpackage

// File: rtl/mem_array.sv
// mem_array: word storage with per-byte synchronous write enables and combinational read.
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic [WORD_BYTES-1:0]          be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] adr,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);
    logic [31:0] mem [DEPTH_WORDS];
    always_ff @(posedge clk) begin
        for (int i = 0; i < WORD_BYTES; i++)
            if (be[i]) mem[adr][8*i +: 8] <= wdata[8*i +: 8];
    end
    assign rdata = mem[adr];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory target with optional wait states.
// Define MEM_RESPONDER_WAIT_EN to enable the WAIT state and its counter; otherwise latency is one clock.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_adr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    state_e state, state_nx, after_accept;
    logic up, accept, commit, we_q, err_q, we_s, err_s, wait_done;
    logic [1:0] size_q, size_s;
    logic [31:0] adr_q, wdata_q, adr_s, wdata_s, wd_s, rd;
    logic [3:0] be_s, be;
    assign accept = req_valid && req_ready;
    // In IDLE the live request is used so a zero-wait store can commit on the accept edge.
    assign we_s    = state == IDLE ? req_we    : we_q;
    assign size_s  = state == IDLE ? req_size  : size_q;
    assign adr_s   = state == IDLE ? req_adr   : adr_q;
    assign wdata_s = state == IDLE ? req_wdata : wdata_q;
    always_comb begin
        be_s  = size_s == SZ_BYTE ? 4'b0001 << adr_s[1:0] : size_s == SZ_HALF ? (adr_s[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wd_s  = size_s == SZ_BYTE ? {4{wdata_s[7:0]}} : size_s == SZ_HALF ? {2{wdata_s[15:0]}} : wdata_s;
        err_s = size_s == 2'b11 || (size_s == SZ_HALF && adr_s[0]) || (size_s == SZ_WORD && adr_s[1:0] != 2'b00) || |adr_s[31:AW+2];
    end
    assign commit = state != RESP && state_nx == RESP;
    assign be     = commit && we_s && !err_s ? be_s : 4'b0000;
`ifdef MEM_RESPONDER_WAIT_EN
    logic [3:0] cnt;
    assign after_accept = WAIT_CYCLES > 0 ? WAIT : RESP;
    assign wait_done    = cnt == 4'd0;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt <= '0;
        else if (accept) cnt <= WAIT_CYCLES > 0 ? 4'(WAIT_CYCLES - 1) : 4'd0;
        else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
    end
`else
    assign after_accept = RESP;
    assign wait_done    = 1'b1;
`endif
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            up    <= 1'b0;
        end else begin
            state <= state_nx;
            up    <= 1'b1;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {we_q, size_q, adr_q, wdata_q, err_q} <= '0;
        end else if (accept) begin
            {we_q, size_q, adr_q, wdata_q, err_q} <= {req_we, req_size, req_adr, req_wdata, err_s};
        end
    end
    always_comb begin
        state_nx = state == IDLE ? (accept ? after_accept : IDLE) :
                   state == WAIT ? (wait_done ? RESP : WAIT) : (rsp_ready ? IDLE : RESP);
    end
    always_comb begin
        req_ready = state == IDLE && up;
        rsp_valid = state == RESP;
        rsp_err   = rsp_valid && err_q;
        rsp_rdata = rsp_valid && !err_q ? rd : '0;
    end
    mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk   (clk),
        .be    (be),
        .adr   (adr_s[AW+1:2]),
        .wdata (wd_s),
        .rdata (rd)
    );
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder; latency expectation follows MEM_RESPONDER_WAIT_EN.
module tb_mem_responder;
    localparam int DEPTH = 64;
    localparam int WC = 2;
`ifdef MEM_RESPONDER_WAIT_EN
    localparam int LAT = WC + 1;
`else
    localparam int LAT = 1;
`endif
    logic clk = 1'b0, reset = 1'b1;
    logic req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
    logic req_ready, rsp_valid, rsp_err;
    logic [1:0] req_size = 2'b00;
    logic [31:0] req_adr = '0, req_wdata = '0, rsp_rdata;
    int checks = 0, errors = 0;
    typedef struct {logic [31:0] rdata; logic err; int lat;} exp_t;
    typedef struct {logic we; logic [1:0] size; logic [31:0] adr; logic [31:0] wdata; logic [31:0] rdata; logic err;} vec_t;
    exp_t sb[$];
    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_adr(req_adr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );
    always #5 clk = ~clk;
    always @(negedge clk) if (reset) begin
        checks++;
        if (rsp_valid && req_ready) begin errors++; $display("FAIL handshake_excl rsp_valid=%b req_ready=%b required not both 1", rsp_valid, req_ready); end
    end
    initial begin #200000; $display("FAIL watchdog timeout"); $fatal(1); end

    task automatic transact(input logic we, input logic [1:0] size, input logic [31:0] adr, input logic [31:0] wdata,
                            input int hold, output logic [31:0] rdata, output logic err, output int lat, output int unstable);
        int n = 0;
        @(negedge clk);
        req_we = we; req_size = size; req_adr = adr; req_wdata = wdata; req_valid = 1'b1; rsp_ready = 1'b0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = ~we; req_size = 2'b11; req_adr = $urandom; req_wdata = $urandom;
        lat = 1;
        while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        if (n >= 20) lat = -1;
        rdata = rsp_rdata; err = rsp_err; unstable = 0;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_adr = 32'h0; req_wdata = 32'hFFFFFFFF;
            @(posedge clk); #1;
            if (!rsp_valid || req_ready || rsp_rdata !== rdata || rsp_err !== err) unstable++;
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks += 4;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b exp 0", req_ready); end
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata got %h exp 0", rsp_rdata); end
        if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b exp 0", rsp_err); end
        @(negedge clk); reset = 1'b1; #1;
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL release_before_edge req_ready got %b exp 0", req_ready); end
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL release_after_edge req_ready got %b exp 1", req_ready); end
    endtask

    task automatic test_word_store();
        logic [31:0] rd; logic er; int lat, un; exp_t e;
        sb.push_back('{32'hDEADBEEF, 1'b0, LAT});
        transact(1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 0, rd, er, lat, un);
        e = sb.pop_front();
        checks += 3;
        if (rd !== e.rdata) begin errors++; $display("FAIL word_store rdata got %h exp %h", rd, e.rdata); end
        if (er !== e.err) begin errors++; $display("FAIL word_store err got %b exp %b", er, e.err); end
        if (lat !== e.lat) begin errors++; $display("FAIL word_store latency got %0d exp %0d", lat, e.lat); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd; logic er; int lat, un; exp_t e;
        vec_t v[6];
        v = '{'{1'b1, 2'b00, 32'h11, 32'h000000AA, 32'hDEADAAEF, 1'b0},
              '{1'b0, 2'b10, 32'h10, 32'h0,        32'hDEADAAEF, 1'b0},
              '{1'b1, 2'b01, 32'h12, 32'hFFFF1234, 32'h1234AAEF, 1'b0},
              '{1'b1, 2'b00, 32'h13, 32'h00000055, 32'h5534AAEF, 1'b0},
              '{1'b1, 2'b01, 32'h10, 32'h00009876, 32'h55349876, 1'b0},
              '{1'b0, 2'b00, 32'h13, 32'h0,        32'h55349876, 1'b0}};
        for (int i = 0; i < 6; i++) begin
            sb.push_back('{v[i].rdata, v[i].err, LAT});
            transact(v[i].we, v[i].size, v[i].adr, v[i].wdata, 0, rd, er, lat, un);
            e = sb.pop_front();
            checks += 3;
            if (rd !== e.rdata) begin errors++; $display("FAIL lanes[%0d] rdata got %h exp %h", i, rd, e.rdata); end
            if (er !== e.err) begin errors++; $display("FAIL lanes[%0d] err got %b exp %b", i, er, e.err); end
            if (lat !== e.lat) begin errors++; $display("FAIL lanes[%0d] latency got %0d exp %0d", i, lat, e.lat); end
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat, un; exp_t e;
        vec_t v[11];
        v = '{'{1'b1, 2'b10, 32'h0,   32'h0BADF00D, 32'h0BADF00D, 1'b0},
              '{1'b0, 2'b01, 32'h13,  32'h0,        32'h0,        1'b1},
              '{1'b0, 2'b10, 32'h10,  32'h0,        32'h55349876, 1'b0},
              '{1'b0, 2'b10, 32'h100, 32'h0,        32'h0,        1'b1},
              '{1'b1, 2'b10, 32'h100, 32'hFFFFFFFF, 32'h0,        1'b1},
              '{1'b1, 2'b11, 32'h0,   32'hFFFFFFFF, 32'h0,        1'b1},
              '{1'b1, 2'b10, 32'h2,   32'hFFFFFFFF, 32'h0,        1'b1},
              '{1'b1, 2'b01, 32'h1,   32'hFFFFFFFF, 32'h0,        1'b1},
              '{1'b0, 2'b10, 32'h0,   32'h0,        32'h0BADF00D, 1'b0},
              '{1'b1, 2'b10, 32'hFC,  32'h11112222, 32'h11112222, 1'b0},
              '{1'b0, 2'b00, 32'hFF,  32'h0,        32'h11112222, 1'b0}};
        for (int i = 0; i < 11; i++) begin
            sb.push_back('{v[i].rdata, v[i].err, LAT});
            transact(v[i].we, v[i].size, v[i].adr, v[i].wdata, 0, rd, er, lat, un);
            e = sb.pop_front();
            checks += 3;
            if (rd !== e.rdata) begin errors++; $display("FAIL errors[%0d] rdata got %h exp %h", i, rd, e.rdata); end
            if (er !== e.err) begin errors++; $display("FAIL errors[%0d] err got %b exp %b", i, er, e.err); end
            if (lat !== e.lat) begin errors++; $display("FAIL errors[%0d] latency got %0d exp %0d", i, lat, e.lat); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat, un; exp_t e;
        sb.push_back('{32'h55349876, 1'b0, LAT});
        transact(1'b0, 2'b10, 32'h10, 32'h0, 5, rd, er, lat, un);
        e = sb.pop_front();
        checks += 3;
        if (rd !== e.rdata) begin errors++; $display("FAIL hold rdata got %h exp %h", rd, e.rdata); end
        if (lat !== e.lat) begin errors++; $display("FAIL hold latency got %0d exp %0d", lat, e.lat); end
        if (un !== 0) begin errors++; $display("FAIL hold unstable_cycles got %0d exp 0", un); end
        sb.push_back('{32'h0BADF00D, 1'b0, LAT});
        transact(1'b0, 2'b10, 32'h0, 32'h0, 0, rd, er, lat, un);
        e = sb.pop_front();
        checks++;
        if (rd !== e.rdata) begin errors++; $display("FAIL hold_ignored_store rdata got %h exp %h", rd, e.rdata); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat, un; exp_t e;
        transact(1'b1, 2'b10, 32'h20, 32'hCAFEF00D, 0, rd, er, lat, un);
        checks++;
        if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL mid_setup rdata got %h exp cafef00d", rd); end
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b10; req_adr = 32'h20; req_wdata = 32'h12345678; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; reset = 1'b0; #1;
        checks += 4;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL mid_req_ready got %b exp 0", req_ready); end
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp_valid got %b exp 0", rsp_valid); end
        if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL mid_rsp_rdata got %h exp 0", rsp_rdata); end
        if (rsp_err !== 1'b0) begin errors++; $display("FAIL mid_rsp_err got %b exp 0", rsp_err); end
        @(negedge clk); reset = 1'b1;
`ifdef MEM_RESPONDER_WAIT_EN
        sb.push_back('{32'hCAFEF00D, 1'b0, LAT});
`else
        sb.push_back('{32'h12345678, 1'b0, LAT});
`endif
        transact(1'b0, 2'b10, 32'h20, 32'h0, 0, rd, er, lat, un);
        e = sb.pop_front();
        checks += 2;
        if (rd !== e.rdata) begin errors++; $display("FAIL mid_reload rdata got %h exp %h", rd, e.rdata); end
        if (lat !== e.lat) begin errors++; $display("FAIL mid_reload latency got %0d exp %0d", lat, e.lat); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, w; logic er; int lat, un; exp_t e;
        for (int i = 0; i < 16; i++) begin
            w = $urandom;
            sb.push_back('{w, 1'b0, LAT});
            transact(1'b1, 2'b10, 32'h40 + 32'(4 * (i % 8)), w, 0, rd, er, lat, un);
            e = sb.pop_front();
            sb.push_back(e);
            transact(1'b0, 2'b10, 32'h40 + 32'(4 * (i % 8)), 32'h0, 0, rd, er, lat, un);
            e = sb.pop_front();
            checks += 2;
            if (rd !== e.rdata || er !== e.err) begin errors++; $display("FAIL b2b[%0d] rdata/err got %h/%b exp %h/%b", i, rd, er, e.rdata, e.err); end
            if (lat !== e.lat) begin errors++; $display("FAIL b2b[%0d] latency got %0d exp %0d", i, lat, e.lat); end
        end
    endtask

    initial begin
        test_reset();
        test_word_store();
        test_byte_lanes();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
